// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the dot-product MAC sequencer.
// The MAC is an 8x8->24 pipeline; only the state encoding is private to the sequencer.
package mac_ctrl_pkg;

  localparam int MAC_DATA_W  = 8;
  localparam int MAC_ACC_W   = 24;
  localparam int MAC_LAT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FEED    = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bundles job command, operand FIFO, MAC drive and result handshake signals.
// master is the sequencer side; slave is the FIFO/MAC/consumer environment side.
interface mac_seq_ctrl_if #(
  parameter int LEN_W = 8
);
  import mac_ctrl_pkg::*;

  logic                  start;
  logic [LEN_W-1:0]      len;
  logic                  busy;
  logic                  a_empty;
  logic [MAC_DATA_W-1:0] a_data;
  logic                  b_empty;
  logic [MAC_DATA_W-1:0] b_data;
  logic                  pop;
  logic                  mac_en;
  logic                  mac_clr;
  logic [MAC_DATA_W-1:0] mac_a;
  logic [MAC_DATA_W-1:0] mac_b;
  logic [MAC_ACC_W-1:0]  mac_cout;
  logic                  res_valid;
  logic [MAC_ACC_W-1:0]  res_data;
  logic                  res_ready;

  modport master (
    input  start, len, a_empty, a_data, b_empty, b_data, mac_cout, res_ready,
    output busy, pop, mac_en, mac_clr, mac_a, mac_b, res_valid, res_data
  );

  modport slave (
    output start, len, a_empty, a_data, b_empty, b_data, mac_cout, res_ready,
    input  busy, pop, mac_en, mac_clr, mac_a, mac_b, res_valid, res_data
  );

endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequences one dot-product job: clear MAC, feed len operand pairs, zero-drain, capture.
// Result valid len+MAC_LAT+1 edges after start plus FIFO stall cycles; result held until res_ready.
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mac_seq_ctrl_if.master io
);

  localparam int DRN_W = (MAC_LAT > 2) ? $clog2(MAC_LAT - 1) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MAC_LAT - 2);

  state_e                 state_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       feed_cnt_q;
  logic [LEN_W-1:0]       feed_cnt_d;
  logic [DRN_W-1:0]       drain_cnt_q;
  logic                   res_valid_q;
  logic [MAC_ACC_W-1:0]   res_data_q;
  logic                   fire;

  assign fire       = !io.a_empty && !io.b_empty;
  assign feed_cnt_d = feed_cnt_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      feed_cnt_q  <= '0;
      drain_cnt_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.start) begin
            len_q   <= io.len;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          feed_cnt_q  <= '0;
          drain_cnt_q <= '0;
          state_q     <= (len_q != '0) ? FEED : DRAIN;
        end
        FEED: begin
          if (fire) begin
            feed_cnt_q <= feed_cnt_d;
            if (feed_cnt_d == len_q) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Zero operands push the last product through and leave the MAC front end at 0.
          if (drain_cnt_q == DRN_LAST) begin
            state_q <= CAPTURE;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRN_W'(1);
          end
        end
        CAPTURE: begin
          res_data_q  <= io.mac_cout;
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (io.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    io.pop     = 1'b0;
    io.mac_en  = 1'b0;
    io.mac_clr = 1'b0;
    io.mac_a   = '0;
    io.mac_b   = '0;
    case (state_q)
      CLEAR: io.mac_clr = 1'b1;
      FEED: begin
        if (fire) begin
          io.pop    = 1'b1;
          io.mac_en = 1'b1;
          io.mac_a  = io.a_data;
          io.mac_b  = io.b_data;
        end
      end
      DRAIN:   io.mac_en = 1'b1;
      default: ;
    endcase
  end

  assign io.busy      = (state_q != IDLE);
  assign io.res_valid = res_valid_q;
  assign io.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with operand FIFO and 4-stage MAC models.
module tb_mac_seq_ctrl;
  import mac_ctrl_pkg::*;

  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.LEN_W(LEN_W)) bus ();

  mac_seq_ctrl #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Operand FIFOs: shared write/read pointers, flushed by reset.
  logic [7:0] a_mem [0:511];
  logic [7:0] b_mem [0:511];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic b_stall = 1'b0;

  assign bus.a_empty = (rd_ptr >= wr_ptr);
  assign bus.b_empty = (rd_ptr >= wr_ptr) || b_stall;
  assign bus.a_data  = a_mem[rd_ptr[8:0]];
  assign bus.b_data  = b_mem[rd_ptr[8:0]];

  int pop_cnt = 0;
  int clr_cnt = 0;
  int overlap_cnt = 0;

  always @(posedge clk) begin
    if (rst) rd_ptr <= wr_ptr;
    else if (bus.pop) rd_ptr <= rd_ptr + 1;
    if (!rst) begin
      if (bus.pop) pop_cnt <= pop_cnt + 1;
      if (bus.mac_clr) clr_cnt <= clr_cnt + 1;
      if (bus.mac_clr && bus.mac_en) overlap_cnt <= overlap_cnt + 1;
    end
  end

  // MAC: input regs -> product -> accumulator -> Cout, all gated by En.
  logic [7:0]  m_a, m_b;
  logic [15:0] m_p;
  logic [23:0] m_acc, m_cout;

  always @(posedge clk) begin
    if (rst || bus.mac_clr) begin
      m_a <= '0; m_b <= '0; m_p <= '0; m_acc <= '0; m_cout <= '0;
    end else if (bus.mac_en) begin
      m_a    <= bus.mac_a;
      m_b    <= bus.mac_b;
      m_p    <= 16'(m_a) * 16'(m_b);
      m_acc  <= m_acc + {8'd0, m_p};
      m_cout <= m_acc;
    end
  end
  assign bus.mac_cout = m_cout;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input logic [7:0] a, input logic [7:0] b);
    a_mem[wr_ptr[8:0]] = a;
    b_mem[wr_ptr[8:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic start_job(input int n);
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_result(input int n0, output int n);
    n = n0;
    while (!bus.res_valid && n < 2000) begin
      tick();
      n = n + 1;
    end
  endtask

  task automatic test_reset;
    tests++;
    if ({bus.busy, bus.pop, bus.mac_en, bus.mac_clr, bus.res_valid} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: busy/pop/en/clr/valid=%b required 00000",
               {bus.busy, bus.pop, bus.mac_en, bus.mac_clr, bus.res_valid});
    end
    tests++;
    if (bus.res_data !== 24'd0) begin
      fails++; $display("FAIL reset_data: got %0d required 0", bus.res_data);
    end
    tests++;
    if ({bus.mac_a, bus.mac_b} !== 16'd0) begin
      fails++; $display("FAIL reset_operands: got %h required 0000", {bus.mac_a, bus.mac_b});
    end
  endtask

  task automatic test_basic;
    int n, p0, c0;
    load_pair(8'd1, 8'd4); load_pair(8'd2, 8'd5); load_pair(8'd3, 8'd6);
    p0 = pop_cnt; c0 = clr_cnt;
    start_job(3);
    wait_result(0, n);
    tests++;
    if (n !== 8) begin fails++; $display("FAIL basic_latency: got %0d required 8", n); end
    tests++;
    if (bus.res_data !== 24'd32) begin fails++; $display("FAIL basic_data: got %0d required 32", bus.res_data); end
    tests++;
    if (pop_cnt - p0 !== 3) begin fails++; $display("FAIL basic_pops: got %0d required 3", pop_cnt - p0); end
    tests++;
    if (clr_cnt - c0 !== 1) begin fails++; $display("FAIL basic_clr: got %0d required 1", clr_cnt - c0); end
    tick();
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_idle: busy=%b required 0", bus.busy); end
  endtask

  task automatic test_stall;
    int n, p0;
    load_pair(8'd1, 8'd4); load_pair(8'd2, 8'd5); load_pair(8'd3, 8'd6);
    p0 = pop_cnt;
    start_job(3);
    tick(); tick();
    b_stall = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({bus.pop, bus.mac_en} !== 2'b00) begin
        fails++; $display("FAIL stall_cycle%0d: pop/en=%b required 00", i, {bus.pop, bus.mac_en});
      end
      tick();
    end
    b_stall = 1'b0;
    wait_result(4, n);
    tests++;
    if (n !== 10) begin fails++; $display("FAIL stall_latency: got %0d required 10", n); end
    tests++;
    if (bus.res_data !== 24'd32) begin fails++; $display("FAIL stall_data: got %0d required 32", bus.res_data); end
    tests++;
    if (pop_cnt - p0 !== 3) begin fails++; $display("FAIL stall_pops: got %0d required 3", pop_cnt - p0); end
    tick();
  endtask

  task automatic test_len0;
    int n, p0;
    p0 = pop_cnt;
    start_job(0);
    wait_result(0, n);
    tests++;
    if (n !== 5) begin fails++; $display("FAIL len0_latency: got %0d required 5", n); end
    tests++;
    if (bus.res_data !== 24'd0) begin fails++; $display("FAIL len0_data: got %0d required 0", bus.res_data); end
    tests++;
    if (pop_cnt - p0 !== 0) begin fails++; $display("FAIL len0_pops: got %0d required 0", pop_cnt - p0); end
    tick();
  endtask

  task automatic test_backpressure;
    int n, p0;
    load_pair(8'd255, 8'd255); load_pair(8'd255, 8'd255);
    bus.res_ready = 1'b0;
    start_job(2);
    wait_result(0, n);
    tests++;
    if (n !== 7) begin fails++; $display("FAIL bp_latency: got %0d required 7", n); end
    load_pair(8'd7, 8'd9);
    p0 = pop_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      bus.len   = LEN_W'(1);
      tick();
      tests++;
      if ({bus.res_valid, bus.res_data} !== {1'b1, 24'd130050}) begin
        fails++; $display("FAIL bp_hold%0d: valid=%b data=%0d required 1/130050", i, bus.res_valid, bus.res_data);
      end
    end
    bus.res_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    tests++;
    if ({bus.busy, bus.res_valid} !== 2'b00) begin
      fails++; $display("FAIL bp_release: busy/valid=%b required 00", {bus.busy, bus.res_valid});
    end
    tests++;
    if (pop_cnt - p0 !== 0) begin fails++; $display("FAIL bp_ignored_start: pops=%0d required 0", pop_cnt - p0); end
    start_job(1);
    wait_result(0, n);
    tests++;
    if (n !== 6) begin fails++; $display("FAIL bp_job2_latency: got %0d required 6", n); end
    tests++;
    if (bus.res_data !== 24'd63) begin fails++; $display("FAIL bp_job2_data: got %0d required 63", bus.res_data); end
    tick();
  endtask

  task automatic test_mid_reset;
    int n, p0;
    load_pair(8'd1, 8'd1); load_pair(8'd2, 8'd2); load_pair(8'd3, 8'd3);
    p0 = pop_cnt;
    start_job(3);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({bus.busy, bus.pop, bus.mac_en, bus.mac_clr, bus.res_valid} !== 5'b0) begin
      fails++; $display("FAIL rst_ctrl: busy/pop/en/clr/valid=%b required 00000",
                        {bus.busy, bus.pop, bus.mac_en, bus.mac_clr, bus.res_valid});
    end
    tests++;
    if ({bus.res_data, bus.mac_a, bus.mac_b} !== 40'd0) begin
      fails++; $display("FAIL rst_data: data=%0d a=%0d b=%0d required 0", bus.res_data, bus.mac_a, bus.mac_b);
    end
    tick(); tick(); tick();
    tests++;
    if (pop_cnt - p0 !== 1) begin fails++; $display("FAIL rst_pops: got %0d required 1", pop_cnt - p0); end
    load_pair(8'd7, 8'd9);
    start_job(1);
    wait_result(0, n);
    tests++;
    if (n !== 6) begin fails++; $display("FAIL rst_job_latency: got %0d required 6", n); end
    tests++;
    if (bus.res_data !== 24'd63) begin fails++; $display("FAIL rst_job_data: got %0d required 63", bus.res_data); end
    tick();
  endtask

  task automatic test_max_len;
    int n, p0;
    for (int i = 0; i < 255; i++) load_pair(8'd255, 8'd255);
    p0 = pop_cnt;
    start_job(255);
    bus.start = 1'b1;
    bus.len   = LEN_W'(3);
    tick(); tick(); tick();
    bus.start = 1'b0;
    wait_result(3, n);
    tests++;
    if (n !== 260) begin fails++; $display("FAIL max_latency: got %0d required 260", n); end
    tests++;
    if (bus.res_data !== 24'd16581375) begin
      fails++; $display("FAIL max_data: got %0d required 16581375", bus.res_data);
    end
    tick();
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL max_idle: busy=%b required 0", bus.busy); end
    tests++;
    if (pop_cnt - p0 !== 255) begin fails++; $display("FAIL max_pops: got %0d required 255", pop_cnt - p0); end
    tests++;
    if (overlap_cnt !== 0) begin fails++; $display("FAIL clr_en_overlap: got %0d required 0", overlap_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = '0;
    bus.res_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    test_reset();
    tick();
    test_basic();
    test_stall();
    test_len0();
    test_backpressure();
    test_mid_reset();
    test_max_len();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Dot-product sequencer for the pipelined 8x8->24 MAC.
- Per job: accepts a start command with an element count, clears the MAC, then pops operand pairs from two first-word-fall-through byte FIFOs (A and B) into the MAC.
- Flushes the MAC pipeline with zero operands, captures the 24-bit accumulation, and holds it on a valid/ready result port.
- Sits between the operand FIFOs and the MAC. The MAC's active-low async reset is driven from the inverted rst at integration.

Parameters:
LEN_W, 8, width of len and of the feed counter; max 255 elements, which guarantees no 24-bit overflow.
MAC_LAT, 4, MAC En-gated stages from operand input to Cout; drain length = MAC_LAT-1.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous and active-high, on the single clock domain clk
start  in  1  job request; sampled only in IDLE
len  in  LEN_W  element count; latched with start
busy  out  1  high whenever state != IDLE
a_empty  in  1  A FIFO empty
a_data  in  8  A FIFO head (valid when !a_empty)
b_empty  in  1  B FIFO empty
b_data  in  8  B FIFO head
pop  out  1  pops A and B together
mac_en  out  1  MAC En
mac_clr  out  1  MAC Clr
mac_a  out  8  MAC Ain
mac_b  out  8  MAC Bin
mac_cout  in  24  MAC Cout
res_valid  out  1  result valid
res_data  out  24  result; stable while res_valid
res_ready  in  1  result consumer ready

Behaviour:
- Reset (rst high at a clk edge): state IDLE, counters 0, res_data 0. All outputs 0 and pop 0. Reset mid-job abandons the job; no further pops.
- Outputs pop, mac_en, mac_clr, mac_a and mac_b are combinational from state, a_empty and b_empty. res_valid and res_data are registered.
- IDLE: start=1 latches len and moves to CLEAR. Otherwise stay. start outside IDLE is ignored.
- CLEAR (1 cycle): mac_clr=1, mac_en=0. Next state is FEED if len!=0, else DRAIN.
- FEED:
  - fire = !a_empty && !b_empty.
  - On fire: pop=1, mac_en=1, mac_a=a_data, mac_b=b_data, feed count +1.
  - On !fire (stall): pop=0, mac_en=0 and the MAC pipeline freezes. The result is unchanged; latency grows by the stall cycles.
  - After the fire that makes count==len, move to DRAIN.
- DRAIN (MAC_LAT-1 cycles): mac_en=1, mac_a=mac_b=0, no pops; then move to CAPTURE.
  - The zero drain also leaves the MAC input and product registers at 0, so no stale product leaks into the next job.
- CAPTURE (1 cycle): mac_en=0. At the next edge, res_data <= mac_cout and res_valid <= 1; move to DONE.
- DONE: res_valid=1 and res_data held. When res_valid && res_ready, res_valid <= 0 and move to IDLE.
  - A start in that same cycle is ignored; it must be re-presented in IDLE.
- Latency without stalls: res_valid rises len+MAC_LAT+1 edges after the edge that samples start.
- Arithmetic: the MAC zero-extends products. 255*65025 = 16,581,375 < 2^24, so no overflow for any legal len.
- mac_clr and mac_en are never high in the same cycle.

Decomposition:
- Package mac_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE);
  - MAC_DATA_W=8, MAC_ACC_W=24, MAC_LAT_DEF=4.
- No sub-module: single FSM with a feed counter and a drain counter. The MAC is instantiated alongside in the integration top, not inside this block.

Test Plan:
- FIFOs always non-empty, start len=3, A={1,2,3}, B={4,5,6} -> res_data=32, res_valid rises 8 edges after start; exactly 3 pops; mac_clr high 1 cycle.
- Same job with b_empty high for 2 cycles after the first pop -> mac_en/pop low in those cycles, res_data=32, res_valid at edge 10.
- len=0 -> no pops, res_data=0, res_valid at edge 5.
- Job 1 len=2 A={255,255}, B={255,255}, with res_ready low 5 cycles -> res_data=130050 held stable; start pulses during DONE ignored. Then job 2 len=1 {7}x{9} -> 63 (no carry-over).
- rst pulsed during FEED after 1 pop -> all outputs 0, busy 0 next cycle. Then job len=1 {7}x{9} -> 63.
- len=255, all operands 255 -> res_data=16581375; start while busy ignored.
